// File: rtl/timer_pkg.sv
// Shared types and constants for the timer set/run control slice.
// Optional build macro TIMER_REPEAT_EN selects auto-reload on expiry.
package timer_pkg;

    localparam int HOURS_W = 5;
    localparam int MS_W    = 6;
    localparam int MAX_MS  = 59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        FS_NONE  = 2'd0,
        FS_HOURS = 2'd1,
        FS_MINS  = 2'd2,
        FS_SECS  = 2'd3
    } field_t;

    // Step a minutes/seconds field by one, wrapping across 0..MAX_MS.
    function automatic logic [MS_W-1:0] ms_step(
        input logic [MS_W-1:0] v,
        input logic            up
    );
        logic [MS_W-1:0] r;
        if (up)
            r = (v >= MS_W'(MAX_MS)) ? '0 : v + 1'b1;
        else
            r = (v == '0) ? MS_W'(MAX_MS) : v - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button synchroniser, stability counter and press pulse.
// Optional build macro TIMER_REPEAT_EN does not affect this block.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/timer_set_ctrl.sv
// Button-driven h:m:s entry and run control ahead of a countdown timer.
// Build macro TIMER_REPEAT_EN: auto-reload on expiry instead of DONE.
module timer_set_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_HOURS       = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_go,
    input  logic [HOURS_W-1:0] timer_hours,
    input  logic [MS_W-1:0]    timer_mins,
    input  logic [MS_W-1:0]    timer_secs,
    output logic [HOURS_W-1:0] hours_o,
    output logic [MS_W-1:0]    mins_o,
    output logic [MS_W-1:0]    secs_o,
    output logic               start_o,
    output logic [1:0]         field_sel,
    output logic               running_o,
    output logic               expired_o
);

    localparam logic [HOURS_W-1:0] MAX_H = HOURS_W'(MAX_HOURS);

    logic w_mode;
    logic w_inc;
    logic w_dec;
    logic w_go;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .i_btn(btn_mode), .o_press(w_mode)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .reset(reset), .i_btn(btn_inc), .o_press(w_inc)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .reset(reset), .i_btn(btn_dec), .o_press(w_dec)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_go (
        .clk(clk), .reset(reset), .i_btn(btn_go), .o_press(w_go)
    );

    state_t             r_state;
    state_t             w_next;
    logic [HOURS_W-1:0] r_hours;
    logic [HOURS_W-1:0] w_hours;
    logic [MS_W-1:0]    r_mins;
    logic [MS_W-1:0]    w_mins;
    logic [MS_W-1:0]    r_secs;
    logic [MS_W-1:0]    w_secs;
    logic               w_nonzero;
    logic               w_timer_zero;
    logic               w_start_ok;
    logic               w_edit;

    assign w_nonzero    = |{r_hours, r_mins, r_secs};
    assign w_timer_zero = ~|{timer_hours, timer_mins, timer_secs};
    assign w_start_ok   = w_go & w_nonzero;
    assign w_edit       = w_inc | w_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_hours <= '0;
            r_mins  <= '0;
            r_secs  <= '0;
        end else begin
            r_state <= w_next;
            r_hours <= w_hours;
            r_mins  <= w_mins;
            r_secs  <= w_secs;
        end
    end

    // Priority go > mode > inc > dec; a zero-value go falls through.
    always_comb begin
        w_next    = r_state;
        w_hours   = r_hours;
        w_mins    = r_mins;
        w_secs    = r_secs;
        start_o   = 1'b0;
        expired_o = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    start_o = 1'b1;
                    w_next  = ST_RUN;
                end else if (w_mode) begin
                    w_next = ST_SET_H;
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (w_start_ok) begin
                    start_o = 1'b1;
                    w_next  = ST_RUN;
                end else if (w_mode) begin
                    w_next = (r_state == ST_SET_H) ? ST_SET_M :
                             (r_state == ST_SET_M) ? ST_SET_S :
                                                     ST_IDLE;
                end else if (w_edit) begin
                    if (r_state == ST_SET_H) begin
                        if (w_inc)
                            w_hours = (r_hours >= MAX_H) ?
                                      '0 : r_hours + 1'b1;
                        else
                            w_hours = (r_hours == '0) ?
                                      MAX_H : r_hours - 1'b1;
                    end else if (r_state == ST_SET_M) begin
                        w_mins = ms_step(r_mins, w_inc);
                    end else begin
                        w_secs = ms_step(r_secs, w_inc);
                    end
                end
            end
            ST_RUN: begin
`ifdef TIMER_REPEAT_EN
                if (w_go) begin
                    w_next = ST_IDLE;
                end else if (w_timer_zero) begin
                    start_o   = 1'b1;
                    expired_o = 1'b1;
                end
`else
                if (w_timer_zero)
                    w_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                expired_o = 1'b1;
                if (w_go || w_mode)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign field_sel = (r_state == ST_SET_H) ? FS_HOURS :
                       (r_state == ST_SET_M) ? FS_MINS  :
                       (r_state == ST_SET_S) ? FS_SECS  :
                                               FS_NONE;
    assign running_o = (r_state == ST_RUN);
    assign hours_o   = r_hours;
    assign mins_o    = r_mins;
    assign secs_o    = r_secs;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Directed bench for timer_set_ctrl with a one-second-per-cycle timer model.
// Covers the default build and TIMER_REPEAT_EN.
module tb_timer_set_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_go = 1'b0;
    logic [4:0] timer_hours;
    logic [5:0] timer_mins;
    logic [5:0] timer_secs;
    logic [4:0] hours_o;
    logic [5:0] mins_o;
    logic [5:0] secs_o;
    logic       start_o;
    logic [1:0] field_sel;
    logic       running_o;
    logic       expired_o;

    int n_checks = 0;
    int n_fail = 0;
    int r_t = 0;

    timer_set_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .MAX_HOURS(23)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .btn_go(btn_go),
        .timer_hours(timer_hours),
        .timer_mins(timer_mins),
        .timer_secs(timer_secs),
        .hours_o(hours_o),
        .mins_o(mins_o),
        .secs_o(secs_o),
        .start_o(start_o),
        .field_sel(field_sel),
        .running_o(running_o),
        .expired_o(expired_o)
    );

    always #5 clk = ~clk;

    // Countdown timer model: loads on start_o, drops one second per cycle.
    always @(posedge clk) begin
        if (start_o)
            r_t <= hours_o * 3600 + mins_o * 60 + secs_o;
        else if (r_t != 0)
            r_t <= r_t - 1;
    end

    assign timer_hours = 5'(r_t / 3600);
    assign timer_mins  = 6'((r_t / 60) % 60);
    assign timer_secs  = 6'(r_t % 60);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_mode = v;
            1: btn_inc  = v;
            2: btn_dec  = v;
            default: btn_go = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(DC + 4);
        set_btn(b, 1'b0);
        tick(DC + 4);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hours"}, 32'(hours_o), 0);
        check({tag, "_mins"}, 32'(mins_o), 0);
        check({tag, "_secs"}, 32'(secs_o), 0);
        check({tag, "_start"}, 32'(start_o), 0);
        check({tag, "_field"}, 32'(field_sel), 0);
        check({tag, "_running"}, 32'(running_o), 0);
        check({tag, "_expired"}, 32'(expired_o), 0);
    endtask

    typedef struct {
        int         btn;
        logic [1:0] fs;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int lat;
        int seen;

        vecs[0]  = '{0, 2'd1, 5'd0,  6'd0,  6'd0};
        vecs[1]  = '{2, 2'd1, 5'd23, 6'd0,  6'd0};
        vecs[2]  = '{1, 2'd1, 5'd0,  6'd0,  6'd0};
        vecs[3]  = '{1, 2'd1, 5'd1,  6'd0,  6'd0};
        vecs[4]  = '{0, 2'd2, 5'd1,  6'd0,  6'd0};
        vecs[5]  = '{2, 2'd2, 5'd1,  6'd59, 6'd0};
        vecs[6]  = '{1, 2'd2, 5'd1,  6'd0,  6'd0};
        vecs[7]  = '{0, 2'd3, 5'd1,  6'd0,  6'd0};
        vecs[8]  = '{2, 2'd3, 5'd1,  6'd0,  6'd59};
        vecs[9]  = '{1, 2'd3, 5'd1,  6'd0,  6'd0};
        vecs[10] = '{0, 2'd0, 5'd1,  6'd0,  6'd0};

        reset = 1'b0;
        tick(2);
        check_all_zero("reset");
        reset = 1'b1;
        tick(1);

        for (int i = 0; i < 11; i++) begin
            press(vecs[i].btn);
            check($sformatf("vec%0d_field", i), 32'(field_sel),
                  32'(vecs[i].fs));
            check($sformatf("vec%0d_hours", i), 32'(hours_o),
                  32'(vecs[i].h));
            check($sformatf("vec%0d_mins", i), 32'(mins_o),
                  32'(vecs[i].m));
            check($sformatf("vec%0d_secs", i), 32'(secs_o),
                  32'(vecs[i].s));
            check($sformatf("vec%0d_running", i), 32'(running_o), 0);
        end

        // Zero guard.
        do_reset();
        seen = 0;
        btn_go = 1'b1;
        repeat (DC + 4) begin
            @(negedge clk);
            if (start_o) seen++;
        end
        btn_go = 1'b0;
        tick(DC + 4);
        check("zero_guard_start", 32'(seen), 0);
        check("zero_guard_field", 32'(field_sel), 0);
        check("zero_guard_running", 32'(running_o), 0);

        // Bounce then steady high.
        do_reset();
        press(0);
        press(0);
        check("bounce_field", 32'(field_sel), 2);
        for (int i = 0; i < 10; i++) begin
            btn_inc = ~i[0];
            @(negedge clk);
        end
        btn_inc = 1'b1;
        tick(6);
        check("bounce_early", 32'(mins_o), 0);
        tick(1);
        check("bounce_latency", 32'(mins_o), 1);
        tick(4);
        btn_inc = 1'b0;
        tick(DC + 4);
        check("bounce_single", 32'(mins_o), 1);

        // inc and dec together.
        for (int i = 0; i < 9; i++) press(1);
        check("mins_ten", 32'(mins_o), 10);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        tick(DC + 4);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        tick(DC + 4);
        check("inc_dec_same", 32'(mins_o), 11);

        // Run 0:0:2 to expiry.
        do_reset();
        press(0);
        press(0);
        press(0);
        press(1);
        press(1);
        check("run_set_secs", 32'(secs_o), 2);
        check("run_set_field", 32'(field_sel), 3);
        btn_go = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (start_o) found = 1;
        end
        check("run_start_seen", 32'(found), 1);
        check("run_start_hours", 32'(hours_o), 0);
        check("run_start_mins", 32'(mins_o), 0);
        check("run_start_secs", 32'(secs_o), 2);
        tick(1);
        check("run_start_one_cycle", 32'(start_o), 0);
        check("run_running", 32'(running_o), 1);
        check("run_field", 32'(field_sel), 0);
        lat = 0;
        while (lat < 20 && !expired_o) begin
            @(negedge clk);
            lat++;
        end
`ifdef TIMER_REPEAT_EN
        check("rep_expiry_latency", 32'(lat), 2);
        check("rep_restart", 32'(start_o), 1);
        check("rep_restart_secs", 32'(secs_o), 2);
        check("rep_running", 32'(running_o), 1);
        tick(1);
        check("rep_expired_pulse", 32'(expired_o), 0);
        check("rep_still_running", 32'(running_o), 1);
        lat = 0;
        while (lat < 20 && !expired_o) begin
            @(negedge clk);
            lat++;
        end
        check("rep_second_latency", 32'(lat), 2);
        check("rep_second_start", 32'(start_o), 1);
`else
        check("run_expiry_latency", 32'(lat), 3);
        check("run_done_not_running", 32'(running_o), 0);
        tick(3);
        check("run_done_sticky", 32'(expired_o), 1);
`endif
        btn_go = 1'b0;
        tick(DC + 4);
        press(3);
        check("ack_field", 32'(field_sel), 0);
        check("ack_running", 32'(running_o), 0);
        check("ack_expired", 32'(expired_o), 0);
        check("ack_hours", 32'(hours_o), 0);
        check("ack_mins", 32'(mins_o), 0);
        check("ack_secs", 32'(secs_o), 2);

        // go and mode together in SET_M, then reset while running.
        do_reset();
        press(0);
        press(0);
        for (int i = 0; i < 5; i++) press(1);
        check("prio_mins", 32'(mins_o), 5);
        btn_go = 1'b1;
        btn_mode = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (start_o) found = 1;
        end
        check("prio_start_seen", 32'(found), 1);
        tick(1);
        check("prio_running", 32'(running_o), 1);
        check("prio_field", 32'(field_sel), 0);
        btn_go = 1'b0;
        btn_mode = 1'b0;
        tick(3);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midrun");
        tick(2);
        reset = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
